// File: rtl/mem_bus_arbiter.sv
// Two-master, three-slave memory bus controller: round-robin arbitration,
// address screening before any slave is touched, and a slave handshake with timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] DM_LIMIT  = 32'h0000_2FFF,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_exc,

  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_exc,

  output logic [2:0]  s_sel,
  output logic [31:0] s_addr,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata_dm,
  input  logic [31:0] s_rdata_dev0,
  input  logic [31:0] s_rdata_dev1,
  input  logic        s_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  exc_q, exc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;

  // Request selection: 1 picks master 1
  logic        gnt_sel;
  logic        req_any;
  logic [31:0] cur_addr;
  logic [1:0]  cur_size;
  logic        cur_we;
  logic [31:0] cur_wdata;

  always_comb begin
    req_any   = m0_req | m1_req;
    gnt_sel   = m1_req & (~m0_req | ~last_grant_q);
    cur_addr  = gnt_sel ? m1_addr  : m0_addr;
    cur_size  = gnt_sel ? m1_size  : m0_size;
    cur_we    = gnt_sel ? m1_we    : m0_we;
    cur_wdata = gnt_sel ? m1_wdata : m0_wdata;
  end

  // Address screening of the request about to be granted
  logic       in_dm, in_dev0, in_dev1, in_dev;
  logic       misalign, ro_store, bad;
  logic [1:0] cur_exc;
  logic [2:0] cur_sel;

  always_comb begin
    in_dm   = cur_addr <= DM_LIMIT;
    in_dev0 = (cur_addr >= DEV0_BASE) && (cur_addr <= DEV0_BASE + 32'd11);
    in_dev1 = (cur_addr >= DEV1_BASE) && (cur_addr <= DEV1_BASE + 32'd11);
    in_dev  = in_dev0 | in_dev1;
    misalign = 1'b0;
    case (cur_size)
      2'b00:   misalign = cur_addr[1:0] != 2'b00;
      2'b01:   misalign = cur_addr[0];
      2'b10:   misalign = 1'b0;
      default: misalign = 1'b1;
    endcase
    ro_store = cur_we && ((cur_addr == DEV0_BASE + 32'd8) || (cur_addr == DEV1_BASE + 32'd8));
    bad      = misalign || !(in_dm || in_dev) || (in_dev && (cur_size != 2'b00)) || ro_store;
    cur_exc  = bad ? {1'b1, cur_we} : 2'b00;
    cur_sel  = {in_dev1, in_dev0, in_dm};
  end

  logic [31:0] slave_rdata;

  always_comb begin
    slave_rdata = ({32{sel_q[0]}} & s_rdata_dm)
                | ({32{sel_q[1]}} & s_rdata_dev0)
                | ({32{sel_q[2]}} & s_rdata_dev1);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    exc_d        = exc_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          gnt_d   = gnt_sel;
          addr_d  = cur_addr;
          size_d  = cur_size;
          we_d    = cur_we;
          wdata_d = cur_wdata;
          sel_d   = cur_sel;
          exc_d   = cur_exc;
          rdata_d = 32'h0;
          cnt_d   = 8'h0;
          state_d = (cur_exc != 2'b00) ? StResp : StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 8'd1;
        if (s_ready) begin
          rdata_d = slave_rdata;
          exc_d   = 2'b00;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          rdata_d = 32'h0;
          exc_d   = {1'b1, we_q};
          state_d = StResp;
        end
      end
      StResp: begin
        last_grant_d = gnt_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      sel_q        <= 3'b000;
      exc_q        <= 2'b00;
      rdata_q      <= 32'h0;
      cnt_q        <= 8'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      exc_q        <= exc_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  logic        in_access, in_resp;
  logic [3:0]  be;
  logic [31:0] wdata_rep;

  always_comb begin
    in_access = state_q == StAccess;
    in_resp   = state_q == StResp;
    case (size_q)
      2'b00: begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
    endcase
    s_sel    = in_access ? sel_q : 3'b000;
    s_addr   = in_access ? addr_q : 32'h0;
    s_we     = in_access & we_q;
    s_be     = in_access ? be : 4'b0000;
    s_wdata  = in_access ? wdata_rep : 32'h0;
    m0_done  = in_resp & ~gnt_q;
    m1_done  = in_resp & gnt_q;
    m0_rdata = m0_done ? rdata_q : 32'h0;
    m0_exc   = m0_done ? exc_q : 2'b00;
    m1_rdata = m1_done ? rdata_q : 32'h0;
    m1_exc   = m1_done ? exc_q : 2'b00;
  end

endmodule
